// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: ROWS x COLS output-stationary systolic MAC tile.
// A column vectors stream in from the left and B row vectors from the top.
// After K beats every PE(r,c) holds sum_k A[r][k]*B[k][c]. The rows then
// drain one per handshake.
// Build option: define SYSTOLIC_TILE_SATURATE_EN to clamp the accumulators
// on every update. Without it, the accumulators wrap modulo 2^ABITS.
module systolic_tile_engine #(
    parameter int DBITS = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int KMAX  = 256,
    parameter int ABITS = 2*DBITS + $clog2(KMAX)
) (
    input  logic                      i_CLK,
    input  logic                      i_RSTN,
    input  logic                      i_START,
    input  logic [$clog2(KMAX+1)-1:0] i_K,
    input  logic [ROWS*DBITS-1:0]     i_A,
    input  logic [COLS*DBITS-1:0]     i_B,
    input  logic                      i_IN_VALID,
    output logic                      o_IN_READY,
    output logic [COLS*ABITS-1:0]     o_OUT_DATA,
    output logic                      o_OUT_VALID,
    input  logic                      i_OUT_READY,
    output logic                      o_OUT_LAST,
    output logic                      o_BUSY,
    output logic                      o_DONE
);
    localparam int KW = $clog2(KMAX+1);
    localparam int FW = $clog2(ROWS+COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [KW-1:0] k_reg, beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_idx;
    logic          start_ok, beat_acc, last_beat, flush_end, out_hs;

    assign start_ok  = (state == S_IDLE) && i_START;
    assign beat_acc  = (state == S_FEED) && i_IN_VALID;
    assign last_beat = beat_acc && ((beat_cnt + KW'(1)) == k_reg);
    assign flush_end = (state == S_FLUSH) && (flush_cnt == FW'(ROWS+COLS-2));
    assign out_hs    = (state == S_DRAIN) && i_OUT_READY;

    // Signed multiply-accumulate, sign-extending the product to ABITS.
    function automatic logic [ABITS-1:0] mac(input logic [ABITS-1:0] acc_in,
                                             input logic [DBITS-1:0] a,
                                             input logic [DBITS-1:0] b);
        logic signed [2*DBITS-1:0] prod;
        logic signed [ABITS-1:0]   prod_x;
`ifdef SYSTOLIC_TILE_SATURATE_EN
        logic signed [ABITS:0]     sum;
`endif
        prod   = (2*DBITS)'($signed(a)) * (2*DBITS)'($signed(b));
        prod_x = ABITS'(prod);
`ifdef SYSTOLIC_TILE_SATURATE_EN
        sum = (ABITS+1)'($signed(acc_in)) + (ABITS+1)'(prod_x);
        if (sum[ABITS] != sum[ABITS-1])
            mac = sum[ABITS] ? {1'b1, {(ABITS-1){1'b0}}} : {1'b0, {(ABITS-1){1'b1}}};
        else
            mac = sum[ABITS-1:0];
`else
        mac = acc_in + prod_x;
`endif
    endfunction

    // State register.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt   = state;
        o_IN_READY  = 1'b0;
        o_OUT_VALID = 1'b0;
        o_OUT_LAST  = 1'b0;
        o_DONE      = 1'b0;
        o_BUSY      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (i_START) state_nxt = (i_K == '0) ? S_FLUSH : S_FEED;
            S_FEED: begin
                o_IN_READY = 1'b1;
                if (last_beat) state_nxt = S_FLUSH;
            end
            S_FLUSH: if (flush_end) state_nxt = S_DRAIN;
            S_DRAIN: begin
                o_OUT_VALID = 1'b1;
                o_OUT_LAST  = (row_idx == RW'(ROWS-1));
                if (i_OUT_READY && o_OUT_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_DONE    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reduction length, beat, flush and drain-row counters.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
        end else begin
            if (start_ok) begin
                k_reg    <= i_K;
                beat_cnt <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            if (state == S_FLUSH) flush_cnt <= flush_end ? '0 : flush_cnt + FW'(1);
            if (start_ok)         row_idx <= '0;
            else if (out_hs)      row_idx <= row_idx + RW'(1);
        end
    end

    logic [DBITS-1:0] a_edge   [ROWS];
    logic             a_edge_v [ROWS];
    logic [DBITS-1:0] b_edge   [COLS];
    logic             b_edge_v [COLS];

    // The input skew delays lane r (or c) by r (or c) cycles. Each datum
    // carries its accept bit as a tag.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_a_skew
        if (gr == 0) begin : g_direct
            assign a_edge[gr]   = i_A[gr*DBITS +: DBITS];
            assign a_edge_v[gr] = beat_acc;
        end else begin : g_delay
            logic [DBITS-1:0] sd [gr];
            logic [gr-1:0]    sv;
            // Shift register for row lane gr.
            always_ff @(posedge i_CLK or negedge i_RSTN) begin
                if (!i_RSTN) begin
                    for (int unsigned i = 0; i < gr; i++) sd[i] <= '0;
                    sv <= '0;
                end else begin
                    sd[0] <= i_A[gr*DBITS +: DBITS];
                    sv[0] <= beat_acc;
                    for (int unsigned i = 1; i < gr; i++) begin
                        sd[i] <= sd[i-1];
                        sv[i] <= sv[i-1];
                    end
                end
            end
            assign a_edge[gr]   = sd[gr-1];
            assign a_edge_v[gr] = sv[gr-1];
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_b_skew
        if (gc == 0) begin : g_direct
            assign b_edge[gc]   = i_B[gc*DBITS +: DBITS];
            assign b_edge_v[gc] = beat_acc;
        end else begin : g_delay
            logic [DBITS-1:0] sd [gc];
            logic [gc-1:0]    sv;
            // Shift register for column lane gc.
            always_ff @(posedge i_CLK or negedge i_RSTN) begin
                if (!i_RSTN) begin
                    for (int unsigned i = 0; i < gc; i++) sd[i] <= '0;
                    sv <= '0;
                end else begin
                    sd[0] <= i_B[gc*DBITS +: DBITS];
                    sv[0] <= beat_acc;
                    for (int unsigned i = 1; i < gc; i++) begin
                        sd[i] <= sd[i-1];
                        sv[i] <= sv[i-1];
                    end
                end
            end
            assign b_edge[gc]   = sd[gc-1];
            assign b_edge_v[gc] = sv[gc-1];
        end
    end

    logic [DBITS-1:0] a_fwd  [ROWS][COLS];
    logic             av_fwd [ROWS][COLS];
    logic [DBITS-1:0] b_fwd  [ROWS][COLS];
    logic             bv_fwd [ROWS][COLS];
    logic [ABITS-1:0] acc_w  [ROWS][COLS];

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic [DBITS-1:0] a_d, b_d, a_q, b_q;
            logic             av_d, bv_d, av_q, bv_q;
            logic [ABITS-1:0] acc_q;

            if (gc == 0) begin : g_a_src_edge
                assign a_d  = a_edge[gr];
                assign av_d = a_edge_v[gr];
            end else begin : g_a_src_pe
                assign a_d  = a_fwd[gr][gc-1];
                assign av_d = av_fwd[gr][gc-1];
            end
            if (gr == 0) begin : g_b_src_edge
                assign b_d  = b_edge[gc];
                assign bv_d = b_edge_v[gc];
            end else begin : g_b_src_pe
                assign b_d  = b_fwd[gr-1][gc];
                assign bv_d = bv_fwd[gr-1][gc];
            end

            // PE: forward operands and accumulate only when both tags are set.
            always_ff @(posedge i_CLK or negedge i_RSTN) begin
                if (!i_RSTN) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    av_q  <= 1'b0;
                    bv_q  <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q  <= a_d;
                    av_q <= av_d;
                    b_q  <= b_d;
                    bv_q <= bv_d;
                    if (start_ok)          acc_q <= '0;
                    else if (av_d && bv_d) acc_q <= mac(acc_q, a_d, b_d);
                end
            end

            assign a_fwd[gr][gc]  = a_q;
            assign av_fwd[gr][gc] = av_q;
            assign b_fwd[gr][gc]  = b_q;
            assign bv_fwd[gr][gc] = bv_q;
            assign acc_w[gr][gc]  = acc_q;
        end
    end

    // Result row mux; the output reads zero outside DRAIN.
    always_comb begin
        o_OUT_DATA = '0;
        if (state == S_DRAIN) begin
            for (int unsigned c = 0; c < COLS; c++)
                o_OUT_DATA[c*ABITS +: ABITS] = acc_w[row_idx][c];
        end
    end
endmodule
